// File: rtl/fetch_dispatch_fsm.sv
// Instruction fetch/dispatch controller.
// Owns the PC, fetches one 16-bit instruction word, classifies its opcode,
// pulses start to the selected execute unit and applies the unit's PC
// update request once it reports done. Unknown opcodes raise a one-cycle
// illegal pulse and are skipped. An all-zero word halts the controller. An
// execute unit that never answers drives it into a terminal fault state.
module fetch_dispatch_fsm #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRd,
  input  logic [15:0]       memData,
  input  logic              memValid,
  output logic [15:0]       instruction,
  output logic [1:0]        unitSel,
  output logic              start,
  input  logic              done,
  input  logic              pcInc,
  input  logic              pcLoad,
  input  logic [ADDR_W-1:0] pcLoadVal,
  output logic [ADDR_W-1:0] pc,
  output logic              illegal,
  output logic              halted,
  output logic              fault
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    DISPATCH,
    EXEC_WAIT,
    ADVANCE,
    HALT,
    FAULT
  } state_t;

  localparam logic [1:0] SEL_ALU    = 2'd0;
  localparam logic [1:0] SEL_MEM    = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_hit;

  // Opcode classification of the latched instruction word.
  logic              is_halt;
  logic              is_valid;
  logic [1:0]        sel_dec;

  // Classify the held instruction. The all-zero word is checked first
  // because its opcode field would otherwise count as illegal.
  // NOTE: every signal driven here gets a default before the case statement;
  // leaving any path unassigned would infer a latch.
  always_comb begin
    is_halt  = (instruction == 16'h0000);
    is_valid = 1'b0;
    sel_dec  = SEL_ALU;
    if (!is_halt) begin
      case (instruction[15:12])
        4'b0100: begin is_valid = 1'b1; sel_dec = SEL_ALU;    end
        4'b1000: begin is_valid = 1'b1; sel_dec = SEL_MEM;    end
        4'b1100: begin is_valid = 1'b1; sel_dec = SEL_BRANCH; end
        default: begin is_valid = 1'b0; sel_dec = SEL_ALU;    end
      endcase
    end
  end

  assign timeout_hit = (wait_cnt == CNT_LAST);

  // State register.
  // NOTE: all clocked state is updated with non-blocking assignments. Every
  // flop then samples pre-edge values, whatever the order of the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = FETCH;
      FETCH:     if (memValid) state_next = DECODE;
      DECODE: begin
        if (is_halt)       state_next = HALT;
        else if (is_valid) state_next = DISPATCH;
        else               state_next = ADVANCE;
      end
      DISPATCH:  state_next = EXEC_WAIT;
      EXEC_WAIT: begin
        if (done)             state_next = ADVANCE;
        else if (timeout_hit) state_next = FAULT;
      end
      ADVANCE:   state_next = FETCH;
      HALT:      state_next = HALT;
      FAULT:     state_next = FAULT;
      default:   state_next = IDLE;
    endcase
  end

  // Instruction register, unit select, PC, execute-wait counter and the
  // registered illegal pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= 16'h0000;
      unitSel     <= SEL_ALU;
      pc          <= RESET_PC;
      wait_cnt    <= '0;
      illegal     <= 1'b0;
    end else begin
      illegal <= (state == DECODE) && !is_halt && !is_valid;
      case (state)
        FETCH: begin
          if (memValid) instruction <= memData;
        end
        DECODE: begin
          if (is_valid)              unitSel <= sel_dec;
          else if (!is_halt)         pc      <= pc + ADDR_W'(1);
        end
        DISPATCH: begin
          wait_cnt <= '0;
        end
        EXEC_WAIT: begin
          if (done) begin
            // A load request overrides a simultaneous increment request.
            if (pcLoad)     pc <= pcLoadVal;
            else if (pcInc) pc <= pc + ADDR_W'(1);
          end else if (!timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs. memAddr follows pc directly so that a fetch always
  // presents the current PC.
  assign memAddr = pc;
  assign memRd   = (state == FETCH);
  assign start   = (state == DISPATCH);
  assign halted  = (state == HALT) || (state == FAULT);
  assign fault   = (state == FAULT);

endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
// Testbench for fetch_dispatch_fsm.
// The stimulus side plays program memory and the execute unit. For each
// instruction it pushes the externally visible events it expects into a
// queue: the fetch, then start, illegal, halt or fault. A reference PC is
// kept in plain arithmetic. A separate monitor watches the DUT outputs on
// the falling edge and pops and compares one event each time the DUT
// presents one.
module tb_fetch_dispatch_fsm;

  localparam int          ADDR_W   = 8;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam int          TIMEOUT  = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  memAddr;
  logic        memRd;
  logic [15:0] memData;
  logic        memValid;
  logic [15:0] instruction;
  logic [1:0]  unitSel;
  logic        start;
  logic        done;
  logic        pcInc;
  logic        pcLoad;
  logic [7:0]  pcLoadVal;
  logic [7:0]  pc;
  logic        illegal;
  logic        halted;
  logic        fault;

  fetch_dispatch_fsm #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .memAddr     (memAddr),
    .memRd       (memRd),
    .memData     (memData),
    .memValid    (memValid),
    .instruction (instruction),
    .unitSel     (unitSel),
    .start       (start),
    .done        (done),
    .pcInc       (pcInc),
    .pcLoad      (pcLoad),
    .pcLoadVal   (pcLoadVal),
    .pc          (pc),
    .illegal     (illegal),
    .halted      (halted),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {EV_FETCH, EV_START, EV_ILLEGAL, EV_HALT, EV_FAULT} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  addr;    // fetch address, or pc expected with the event
    int          cycles;  // memRd high cycles for a fetch
    logic [15:0] instr;
    logic [1:0]  sel;
  } ev_t;

  localparam int C_ILLEGAL = -1;
  localparam int C_HALT    = -2;

  localparam logic [30:0] RESET_VEC = {RESET_PC, 16'h0000, 2'b00, 5'b00000};

  ev_t        exp_q[$];
  logic [7:0] m_pc;
  bit         abort;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] obs_vec();
    return {pc, instruction, unitSel, memRd, start, illegal, halted, fault};
  endfunction

  // Reference classification straight from the opcode table.
  function automatic int classify(input logic [15:0] w);
    if (w == 16'h0000) return C_HALT;
    case (w[15:12])
      4'h4:    return 0;
      4'h8:    return 1;
      4'hC:    return 2;
      default: return C_ILLEGAL;
    endcase
  endfunction

  function automatic logic [15:0] rand_word(input int cls);
    logic [3:0] nib;
    if (cls == 0) return {4'h4, 12'($urandom)};
    if (cls == 1) return {4'h8, 12'($urandom)};
    if (cls == 2) return {4'hC, 12'($urandom)};
    nib = 4'($urandom);
    while (nib == 4'h4 || nib == 4'h8 || nib == 4'hC) nib = 4'($urandom);
    return {nib, 12'($urandom_range(1, 4095))};
  endfunction

  function automatic void push_ev(input ev_kind_t k, input logic [7:0] a, input int c,
                                  input logic [15:0] w, input logic [1:0] s);
    ev_t e;
    e.kind = k; e.addr = a; e.cycles = c; e.instr = w; e.sel = s;
    exp_q.push_back(e);
  endfunction

  task automatic pop_expect(input ev_kind_t k, output ev_t e, output bit ok);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      ok = 1'b0;
      $display("FAIL unexpected event: kind=%0d with no expectation pending (t=%0t)", k, $time);
    end else begin
      e = exp_q.pop_front();
      check("event order", 32'(k), 32'(e.kind));
      ok = (k == e.kind);
    end
  endtask

  // Asserts reset between clock edges, checks that it takes effect at once,
  // then releases it and restarts the reference PC.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    memValid = 1'b0; done = 1'b0; pcLoad = 1'b0; pcInc = 1'b0;
    #1;
    check("async reset outputs", 32'(obs_vec()), 32'(RESET_VEC));
    check("async reset memAddr", 32'(memAddr), 32'(RESET_PC));
    repeat (2) @(negedge clk);
    #2;
    rst  = 1'b1;
    m_pc = RESET_PC;
  endtask

  // One instruction: w memory wait cycles, done on EXEC_WAIT cycle d
  // (d > TIMEOUT means never), early=1 raises a spurious done during
  // DISPATCH, rst_at>0 resets the DUT part-way through EXEC_WAIT.
  task automatic run_instr(input logic [15:0] word, input int w, input int d,
                           input bit ld, input bit inc, input logic [7:0] lv,
                           input bit early, input int rst_at);
    int         cls;
    int         n;
    logic [7:0] nxt;
    if (abort) return;
    cls = classify(word);
    push_ev(EV_FETCH, m_pc, w + 1, word, 2'd0);
    if (cls == C_HALT) begin
      push_ev(EV_HALT, m_pc, 0, word, 2'd0);
    end else if (cls == C_ILLEGAL) begin
      nxt = m_pc + 8'd1;
      push_ev(EV_ILLEGAL, nxt, 0, word, 2'd0);
      m_pc = nxt;
    end else begin
      push_ev(EV_START, m_pc, 0, word, 2'(cls));
      if (rst_at == 0 && d > TIMEOUT) push_ev(EV_FAULT, m_pc, 0, word, 2'd0);
    end

    n = 0;
    while (!memRd && n < 64) begin @(negedge clk); n++; end
    if (!memRd) begin
      check("fetch request wait", 32'(memRd), 32'd1);
      abort = 1'b1;
      return;
    end
    for (int k = 0; k < w; k++) begin
      memValid = 1'b0;
      memData  = 16'($urandom);
      @(negedge clk);
    end
    memValid = 1'b1;
    memData  = word;
    @(negedge clk);
    memValid = 1'b0;
    memData  = 16'($urandom);

    if (cls == C_HALT) begin
      repeat (4) @(negedge clk);
      apply_reset();
      return;
    end
    if (cls == C_ILLEGAL) return;

    n = 0;
    while (!start && n < 8) begin @(negedge clk); n++; end
    if (!start) begin
      check("dispatch wait", 32'(start), 32'd1);
      abort = 1'b1;
      return;
    end
    if (early) begin
      done = 1'b1; pcLoad = 1'b1; pcInc = 1'b1; pcLoadVal = 8'($urandom);
    end
    if (rst_at > 0) begin
      repeat (rst_at) @(negedge clk);
      apply_reset();
      return;
    end
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      if (k == d) begin
        done = 1'b1; pcLoad = ld; pcInc = inc; pcLoadVal = lv;
      end else begin
        done = 1'b0; pcLoad = 1'($urandom); pcInc = 1'($urandom); pcLoadVal = 8'($urandom);
      end
    end
    @(negedge clk);
    done = 1'b0; pcLoad = 1'b0; pcInc = 1'b0;
    if (d <= TIMEOUT) begin
      if (ld)       m_pc = lv;
      else if (inc) m_pc = m_pc + 8'd1;
    end else begin
      repeat (4) @(negedge clk);
      apply_reset();
    end
  endtask

  // Monitor: compares every event the DUT presents against the queue.
  initial begin
    int         rd_cnt;
    logic [7:0] rd_addr;
    bit         addr_moved;
    int         fall_cyc;
    int         cyc;
    bit         prev_halted;
    ev_t        e;
    bit         ok;
    rd_cnt = 0; rd_addr = '0; addr_moved = 1'b0; fall_cyc = -10; cyc = 0; prev_halted = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        check("reset outputs", 32'(obs_vec()), 32'(RESET_VEC));
        rd_cnt = 0;
        prev_halted = 1'b0;
        continue;
      end
      if (memRd) begin
        if (rd_cnt == 0) begin
          rd_addr    = memAddr;
          addr_moved = 1'b0;
        end else if (memAddr !== rd_addr) begin
          addr_moved = 1'b1;
        end
        rd_cnt++;
      end else if (rd_cnt > 0) begin
        pop_expect(EV_FETCH, e, ok);
        if (ok) begin
          check("fetch address", 32'(rd_addr), 32'(e.addr));
          check("fetch address stable", 32'(addr_moved), 32'd0);
          check("fetch request cycles", 32'(rd_cnt), 32'(e.cycles));
          check("captured instruction", 32'(instruction), 32'(e.instr));
        end
        rd_cnt   = 0;
        fall_cyc = cyc;
      end
      if (start) begin
        pop_expect(EV_START, e, ok);
        if (ok) begin
          check("dispatched instruction", 32'(instruction), 32'(e.instr));
          check("dispatched unitSel", 32'(unitSel), 32'(e.sel));
          check("start latency after decode", 32'(cyc - fall_cyc), 32'd1);
        end
      end
      if (illegal) begin
        pop_expect(EV_ILLEGAL, e, ok);
        if (ok) begin
          check("illegal pc skip", 32'(pc), 32'(e.addr));
          check("illegal latency after decode", 32'(cyc - fall_cyc), 32'd1);
        end
      end
      if (fault) check("fault implies halted", 32'(halted), 32'd1);
      if (halted && !prev_halted) begin
        pop_expect(fault ? EV_FAULT : EV_HALT, e, ok);
        if (ok) begin
          check("terminal pc", 32'(pc), 32'(e.addr));
          check("terminal instruction", 32'(instruction), 32'(e.instr));
          if (e.kind == EV_HALT) check("halt latency after decode", 32'(cyc - fall_cyc), 32'd1);
        end
      end
      prev_halted = halted;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  // Stimulus.
  initial begin
    int         r;
    logic [15:0] word;
    rst = 1'b0;
    memData = 16'h0000; memValid = 1'b0;
    done = 1'b0; pcInc = 1'b0; pcLoad = 1'b0; pcLoadVal = 8'h00;
    m_pc  = RESET_PC;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;

    // Directed cases.
    run_instr(16'h4042, 0, 2,           1'b0, 1'b1, 8'h00, 1'b0, 0); // MOV, pc 0->1
    run_instr(16'h8123, 3, 1,           1'b0, 1'b1, 8'h00, 1'b0, 0); // memory wait states
    run_instr(16'hC005, 0, 1,           1'b1, 1'b1, 8'h40, 1'b0, 0); // load wins over inc
    run_instr(16'hF123, 0, 1,           1'b0, 1'b0, 8'h00, 1'b0, 0); // illegal, pc+1
    run_instr(16'hC000, 0, 1,           1'b1, 1'b0, 8'hFF, 1'b1, 0); // early done ignored, pc=FF
    run_instr(16'h4042, 1, 1,           1'b0, 1'b1, 8'h00, 1'b0, 0); // pc wraps FF->00
    run_instr(16'h4001, 0, TIMEOUT,     1'b0, 1'b1, 8'h00, 1'b0, 0); // done on last allowed cycle
    run_instr(16'h8002, 0, TIMEOUT + 1, 1'b0, 1'b0, 8'h00, 1'b0, 0); // timeout fault, then reset
    run_instr(16'h4003, 0, 1,           1'b0, 1'b1, 8'h00, 1'b0, 0); // restart from RESET_PC
    run_instr(16'h0000, 0, 1,           1'b0, 1'b0, 8'h00, 1'b0, 0); // halt, then reset
    run_instr(16'h4042, 2, 1,           1'b0, 1'b0, 8'h00, 1'b0, 2); // reset mid EXEC_WAIT

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      if (r <= 5)       word = rand_word(0);
      else if (r <= 10) word = rand_word(1);
      else if (r <= 15) word = rand_word(2);
      else if (r <= 17) word = rand_word(3);
      else if (r == 18) word = rand_word($urandom_range(0, 2));
      else              word = 16'h0000;
      run_instr(word, $urandom_range(0, 3),
                (r == 18) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT),
                1'($urandom), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0), 0);
    end

    repeat (10) @(negedge clk);
    check("pending expectations", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
